serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operands a, b, b_in present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, WIDTH, minuend (unsigned).
REQ-007 SHALL have port b, input, WIDTH, subtrahend (unsigned).
REQ-008 SHALL have port b_in, input, 1, initial borrow-in.
REQ-009 SHALL have port out_valid, output, 1, diff/b_out valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port diff, output, WIDTH, a - b - b_in modulo 2^WIDTH.
REQ-012 SHALL have port b_out, output, 1, final borrow: 1 iff a < b + b_in.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, HOLD; only IDLE asserts in_ready, only HOLD asserts out_valid.
REQ-014 IDLE: on edge with in_valid=1, SHALL load a, b into shift registers, load borrow register with b_in, clear bit counter, go to SHIFT; otherwise remain IDLE.
REQ-015 SHIFT: each edge SHALL feed LSBs of a/b shift registers plus borrow register through one 1-bit full subtractor, shift difference bit into result register MSB, update borrow register, increment counter.
REQ-016 SHIFT SHALL last exactly WIDTH edges, LSB first; after edge WIDTH transition to HOLD.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-018 HOLD: diff and b_out SHALL be stable; on edge with out_ready=1 go to IDLE; out_ready=0 stalls indefinitely with outputs held.
REQ-019 in_valid during SHIFT or HOLD SHALL be ignored (no operand capture, no state change).
REQ-020 out_ready outside HOLD SHALL have no effect.
REQ-021 Throughput: minimum accept-to-accept spacing WIDTH+2 edges (accept, WIDTH shift, 1 handshake edge).
REQ-022 diff SHALL equal result register; b_out SHALL equal borrow register; both meaningful only while out_valid=1.
REQ-023 Arithmetic: per bit d = a^b^bin; bout = (~a&b) | (~a&bin) | (b&bin).

Reset
REQ-024 reset=1 SHALL immediately (no clock) force state IDLE, shift/result registers 0, borrow 0, counter 0.
REQ-025 Outputs during/after reset: in_ready=1, out_valid=0, diff=0, b_out=0.
REQ-026 reset asserted mid-SHIFT or in HOLD SHALL abort the operation; no partial result ever presented.
REQ-027 First accept SHALL be possible on first rising edge after reset deasserts.

Structure
REQ-028 Shared package SHALL hold state encoding (IDLE=2'b00, SHIFT=2'b01, HOLD=2'b10) and default WIDTH constant.
REQ-029 1-bit datapath SHALL be a sub-module full_subtractor_1_bit (inputs x, y, b_in; outputs d, b_out), built from gate primitives only (and, or, not, up to 4 inputs), instantiated once.
REQ-030 Counter width SHALL be clog2(WIDTH+1); no combinational path from in_valid to in_ready or out_ready to out_valid.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, b_in=0 -> after 8 edges out_valid=1, diff=0x02, b_out=0.
REQ-032 a=0x03, b=0x05, b_in=0 -> diff=0xFE, b_out=1; a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1.
REQ-033 out_ready held 0 for 20 cycles in HOLD -> out_valid stays 1, diff unchanged; new in_valid ignored until return to IDLE.
REQ-034 reset pulsed at shift edge 4 of a=0xAA, b=0x55 -> out_valid=0, in_ready=1, diff=0 at once; next op 0xAA-0x55 -> 0x55, b_out=0.
REQ-035 Exhaustive sub-module check: all 8 (x,y,b_in) combos match REQ-023; random 1000 operand pairs vs reference model, back-to-back with out_ready=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_1_bit.sv
// One-bit full subtractor built only from and/or/not gate primitives.
module full_subtractor_1_bit (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  logic nx, ny, nb;
  logic m0, m1, m2, m3;
  logic t0, t1, t2;

  not g_nx (nx, x);
  not g_ny (ny, y);
  not g_nb (nb, b_in);

  // Difference is the odd-parity function of the three inputs, as a sum of minterms.
  and g_m0 (m0, x,  ny, nb);
  and g_m1 (m1, nx, y,  nb);
  and g_m2 (m2, nx, ny, b_in);
  and g_m3 (m3, x,  y,  b_in);
  or  g_d  (d, m0, m1, m2, m3);

  and g_t0 (t0, nx, y);
  and g_t1 (t1, nx, b_in);
  and g_t2 (t2, y,  b_in);
  or  g_bo (b_out, t0, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in: LSB-first over WIDTH clocks, result held until consumed.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output state_t           fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid are pure functions of the state register, never of the partner's signal.

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             fs_d, fs_b;

  full_subtractor_1_bit u_fs (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .b_in  (borrow),
    .d     (fs_d),
    .b_out (fs_b)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at res[0].
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res    <= {fs_d, res[WIDTH-1:1]};
          borrow <= fs_b;
          cnt    <= cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign diff      = res;
  assign b_out     = borrow;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with a plain-arithmetic reference model.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         b_out;
  state_t       fsm_state;

  logic fx, fy, fb, fd, fbo;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .fsm_state (fsm_state)
  );

  full_subtractor_1_bit u_fs_check (
    .x (fx), .y (fy), .b_in (fb), .d (fd), .b_out (fbo)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model: {borrow, diff} of a - b - bin in ordinary integer arithmetic
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    longint t;
    logic [63:0] tv;
    t  = longint'(x) - longint'(y) - longint'(bi);
    tv = t;
    return {(t < 0), tv[W-1:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // driver: call #1 after a rising edge; returns #1 after the accepting edge
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi);
    int budget;
    a = xa; b = xb; b_in = xbi; in_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(ref_sub(xa, xb, xbi));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clock);
      budget++;
    end
    check("drain", exp_q.size(), 0);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {b_out, diff}, 0);
          if (n_fail == 0) n_fail++;
        end else begin
          e = exp_q.pop_front();
          check("result", {b_out, diff}, e);
        end
      end
    end
  end

  initial begin
    logic [W:0] e;
    int t;
    int budget;

    // reset state, including before any clock edge
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);

    // full subtractor exhaustive
    for (int i = 0; i < 8; i++) begin
      fx = i[2]; fy = i[1]; fb = i[0];
      #1;
      t = int'(fx) - int'(fy) - int'(fb);
      check("fs_d", fd, t & 1);
      check("fs_b_out", fbo, (t < 0) ? 1 : 0);
    end

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // directed cases with exact latency check
    send(8'h05, 8'h03, 1'b0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clock);
      #1;
      check("latency_out_valid", out_valid, (k == W) ? 1 : 0);
    end
    wait_drain();
    send(8'h03, 8'h05, 1'b0);
    wait_drain();
    send(8'h00, 8'h00, 1'b1);
    wait_drain();
    send(8'hFF, 8'hFF, 1'b1);
    wait_drain();
    send(8'h80, 8'h7F, 1'b1);
    wait_drain();

    // stall in HOLD with extra in_valid traffic
    out_ready = 1'b0;
    e = ref_sub(8'h9C, 8'h27, 1'b1);
    send(8'h9C, 8'h27, 1'b1);
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(posedge clock);
      #1;
      budget++;
    end
    check("stall_reach_hold", out_valid, 1);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      @(posedge clock);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_diff", {b_out, diff}, e);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clock);
    #1;
    check("no_capture_during_hold", out_valid, 0);

    // reset in the middle of a shift
    send(8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_diff", diff, 0);
    check("abort_b_out", b_out, 0);
    @(negedge clock);
    reset = 1'b0;
    a = 8'hAA; b = 8'h55; b_in = 1'b0; in_valid = 1'b1;
    exp_q.push_back(ref_sub(8'hAA, 8'h55, 1'b0));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("accept_after_reset", in_ready, 0);
    wait_drain();

    // random back-to-back
    for (int n = 0; n < 1000; n++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
